geofence_sorter: RTL

//  Upstream stage of geofence: collects one frame (1 target + NREC receivers, each X/Y/R),

---
 rtl/geofence_sorter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/geofence_sorter.sv
// Buffers one geofence frame (target + NREC receivers), sorts receivers r1..r(NREC-1)
// counter-clockwise around pivot r0 with a fixed-length bubble sort, then streams the frame.
module geofence_sorter #(
  parameter int CW   = 10,
  parameter int RW   = 11,
  parameter int NREC = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic [RW-1:0] R,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic [RW-1:0] out_r,
  output logic [2:0]    out_idx,
  output logic          out_last
);

  localparam int AW   = 3;
  localparam int SCYC = (NREC - 2) * (NREC - 2);
  localparam int CNTW = $clog2(SCYC + 1);
  localparam int PW   = 2 * CW + 3;

  typedef enum logic [1:0] {LOAD, SORT, SEND} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_x [0:NREC];
  logic [CW-1:0]   r_y [0:NREC];
  logic [RW-1:0]   r_r [0:NREC];
  logic [AW-1:0]   r_wcnt;
  logic [AW-1:0]   r_pair;
  logic [CNTW-1:0] r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [CW-1:0]   r_out_x;
  logic [CW-1:0]   r_out_y;
  logic [RW-1:0]   r_out_r;
  logic [AW-1:0]   r_out_idx;
  logic            r_out_last;

  // Buffer slot 0 is the target, slot 1 the pivot r0; r_pair walks receiver pairs (k,k+1).
  logic [AW-1:0]        w_ia;
  logic [AW-1:0]        w_ib;
  logic [AW-1:0]        w_nidx;
  logic signed [CW:0]   w_dxa;
  logic signed [CW:0]   w_dya;
  logic signed [CW:0]   w_dxb;
  logic signed [CW:0]   w_dyb;
  logic signed [PW-1:0] w_cross;
  logic                 w_swap;

  assign w_ia   = r_pair + AW'(1);
  assign w_ib   = r_pair + AW'(2);
  assign w_nidx = r_out_idx + AW'(1);

  assign w_dxa = $signed({1'b0, r_x[w_ia]}) - $signed({1'b0, r_x[1]});
  assign w_dya = $signed({1'b0, r_y[w_ia]}) - $signed({1'b0, r_y[1]});
  assign w_dxb = $signed({1'b0, r_x[w_ib]}) - $signed({1'b0, r_x[1]});
  assign w_dyb = $signed({1'b0, r_y[w_ib]}) - $signed({1'b0, r_y[1]});

  assign w_cross = (PW'(w_dxa) * PW'(w_dyb)) - (PW'(w_dxb) * PW'(w_dya));
  assign w_swap  = w_cross[PW-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_wcnt      <= '0;
      r_pair      <= AW'(1);
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_r     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i <= NREC; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_r[i] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (in_valid) begin
            r_x[r_wcnt] <= X;
            r_y[r_wcnt] <= Y;
            r_r[r_wcnt] <= (r_wcnt == '0) ? '0 : R;
            if (r_wcnt == AW'(NREC)) begin
              r_wcnt     <= '0;
              r_in_ready <= 1'b0;
              r_cnt      <= '0;
              r_pair     <= AW'(1);
              r_state    <= SORT;
            end else begin
              r_wcnt <= r_wcnt + AW'(1);
            end
          end
        end
        SORT: begin
          if (r_cnt == CNTW'(SCYC)) begin
            r_out_x     <= r_x[0];
            r_out_y     <= r_y[0];
            r_out_r     <= r_r[0];
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end else begin
            r_cnt  <= r_cnt + CNTW'(1);
            r_pair <= (r_pair == AW'(NREC - 2)) ? AW'(1) : r_pair + AW'(1);
            if (w_swap) begin
              r_x[w_ia] <= r_x[w_ib];
              r_y[w_ia] <= r_y[w_ib];
              r_r[w_ia] <= r_r[w_ib];
              r_x[w_ib] <= r_x[w_ia];
              r_y[w_ib] <= r_y[w_ia];
              r_r[w_ib] <= r_r[w_ia];
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (r_out_idx == AW'(NREC)) begin
              r_out_valid <= 1'b0;
              r_out_x     <= '0;
              r_out_y     <= '0;
              r_out_r     <= '0;
              r_out_idx   <= '0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= LOAD;
            end else begin
              r_out_x    <= r_x[w_nidx];
              r_out_y    <= r_y[w_nidx];
              r_out_r    <= r_r[w_nidx];
              r_out_idx  <= w_nidx;
              r_out_last <= (w_nidx == AW'(NREC));
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_r     = r_out_r;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule
